// File: rtl/dec_line_reader_pkg.sv
// dec_line_reader_pkg
//   Shared definitions for the decimal line reader:
//   - FSM state encodings (legacy localparam values) and the state_t enum
//   - ASCII constants used by the line parser
//   - is_digit() helper
package dec_line_reader_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        CONVERT = ST_CONVERT,
        DONE    = ST_DONE
    } state_t;

    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] BS   = 8'h08;
    localparam logic [7:0] DEL  = 8'h7F;
    localparam logic [7:0] DIG0 = 8'h30;
    localparam logic [7:0] DIG9 = 8'h39;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= DIG0) && (b <= DIG9);
    endfunction

endpackage

// File: rtl/dec_line_reader_if.sv
// dec_line_reader_if
//   UART-side handshake bundle of the line reader.
//   received        : one-cycle receive strobe
//   rx_byte         : received byte, valid with received
//   is_transmitting : UART transmitter busy
//   transmit        : one-cycle echo request
//   tx_byte         : echo byte, stable in the transmit cycle
//   modport master  : the line reader side
//   modport slave   : the UART side
interface dec_line_reader_if;

    logic       received;
    logic [7:0] rx_byte;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;

    modport master (
        input  received, rx_byte, is_transmitting,
        output transmit, tx_byte
    );

    modport slave (
        output received, rx_byte, is_transmitting,
        input  transmit, tx_byte
    );

endinterface

// File: rtl/dec_accum.sv
// dec_accum
//   Horner multiply-add-saturate accumulator: acc = acc*10 + digit.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clear      : zero the accumulator and overflow flag
//   i_en         : apply one Horner step with i_digit this cycle
//   i_digit      : decimal digit 0..9
//   o_value      : saturated result including this cycle's step
//   o_ovf        : saturation occurred (sticky across steps)
module dec_accum #(
    parameter int VAL_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [3:0]       i_digit,
    output logic [VAL_W-1:0] o_value,
    output logic             o_ovf
);

    localparam int ACC_W = VAL_W + 4;
    localparam logic [ACC_W+3:0] SAT = {{(ACC_W+4-VAL_W){1'b0}}, {VAL_W{1'b1}}};

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;
    logic [ACC_W+3:0] w_sum;

    // acc*10 as acc*8 + acc*2, evaluated wide enough to never wrap
    assign w_sum = ({4'b0, r_acc} << 3) + ({4'b0, r_acc} << 1) + {{ACC_W{1'b0}}, i_digit};

    // Once saturated, stay pinned at all-ones for the rest of the line
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        if (i_en) begin
            if (r_ovf || (w_sum > SAT)) begin
                w_acc_nxt = SAT[ACC_W-1:0];
                w_ovf_nxt = 1'b1;
            end else begin
                w_acc_nxt = w_sum[ACC_W-1:0];
            end
        end
    end

    assign o_value = w_acc_nxt[VAL_W-1:0];
    assign o_ovf   = w_ovf_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

endmodule

// File: rtl/dec_line_reader.sv
// dec_line_reader
//   Collects decimal digits from a UART byte stream, echoes accepted bytes,
//   and on CR converts the buffered digits to a saturated binary value.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle pulse, clears the buffer and begins a new line
//   uart         : dec_line_reader_if.master (received/rx_byte/is_transmitting in,
//                  transmit/tx_byte out)
//   busy         : state is not IDLE
//   done         : one-cycle pulse when value/ovf are valid
//   value, ovf   : converted number and saturation flag, held until next start
//   ndigits      : digits currently buffered
//   Optional: define DEC_LINE_READER_BACKSPACE_EN to make BS/DEL erase a digit.
module dec_line_reader
    import dec_line_reader_pkg::*;
#(
    parameter int MAX_DIGITS = 5,
    parameter int VAL_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    dec_line_reader_if.master                 uart,
    output logic                              busy,
    output logic                              done,
    output logic [VAL_W-1:0]                  value,
    output logic                              ovf,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   ndigits
);

    localparam int ND_W = $clog2(MAX_DIGITS + 1);

    state_t            r_state;
    logic [3:0]        r_buf [MAX_DIGITS];
    logic [ND_W-1:0]   r_ndigits;
    logic [ND_W-1:0]   r_idx;
    logic              r_pend;
    logic              r_cr_pend;
    logic [7:0]        r_tx_byte;
    logic [VAL_W-1:0]  r_value;
    logic              r_ovf;

    logic              w_transmit;
    logic              w_last;
    logic              w_acc_clear;
    logic              w_acc_en;
    logic [VAL_W-1:0]  w_acc_value;
    logic              w_acc_ovf;

    // Echo fires combinationally on the first not-busy cycle; a start in the
    // same cycle discards it instead.
    assign w_transmit  = r_pend && !uart.is_transmitting && !start;
    // A line with no digits still spends one CONVERT cycle.
    assign w_last      = (r_ndigits == '0) || (r_idx == r_ndigits - 1'b1);
    assign w_acc_clear = (r_state != CONVERT);
    assign w_acc_en    = (r_state == CONVERT) && (r_ndigits != '0);

    dec_accum #(
        .VAL_W (VAL_W)
    ) u_accum (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_acc_clear),
        .i_en    (w_acc_en),
        .i_digit (r_buf[r_idx]),
        .o_value (w_acc_value),
        .o_ovf   (w_acc_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            for (int unsigned i = 0; i < MAX_DIGITS; i++) r_buf[i] <= '0;
            r_ndigits <= '0;
            r_idx     <= '0;
            r_pend    <= 1'b0;
            r_cr_pend <= 1'b0;
            r_tx_byte <= '0;
            r_value   <= '0;
            r_ovf     <= 1'b0;
        end else if (start) begin
            r_state   <= COLLECT;
            r_ndigits <= '0;
            r_idx     <= '0;
            r_pend    <= 1'b0;
            r_cr_pend <= 1'b0;
            r_value   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_transmit) begin
                        r_pend <= 1'b0;
                        if (r_cr_pend) begin
                            r_cr_pend <= 1'b0;
                            r_idx     <= '0;
                            r_state   <= CONVERT;
                        end
                    end else if (uart.received && !r_pend) begin
                        if (is_digit(uart.rx_byte) && (r_ndigits < ND_W'(MAX_DIGITS))) begin
                            r_buf[r_ndigits] <= uart.rx_byte[3:0];
                            r_ndigits        <= r_ndigits + 1'b1;
                            r_pend           <= 1'b1;
                            r_tx_byte        <= uart.rx_byte;
                        end else if (uart.rx_byte == CR) begin
                            r_pend    <= 1'b1;
                            r_cr_pend <= 1'b1;
                            r_tx_byte <= CR;
                        end
`ifdef DEC_LINE_READER_BACKSPACE_EN
                        else if (((uart.rx_byte == BS) || (uart.rx_byte == DEL))
                                 && (r_ndigits != '0)) begin
                            r_ndigits <= r_ndigits - 1'b1;
                            r_pend    <= 1'b1;
                            r_tx_byte <= BS;
                        end
`endif
                    end
                end
                CONVERT: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_value <= w_acc_value;
                        r_ovf   <= w_acc_ovf;
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: ;
            endcase
        end
    end

    assign uart.transmit = w_transmit;
    assign uart.tx_byte  = r_tx_byte;
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign value         = r_value;
    assign ovf           = r_ovf;
    assign ndigits       = r_ndigits;

endmodule

// File: tb/tb_dec_line_reader.sv
// tb_dec_line_reader
//   Directed bench for dec_line_reader. A line-level model (digit queue,
//   pending echo, remaining convert cycles, value by integer arithmetic)
//   is compared against the DUT every cycle; directed cases add literal
//   expectations for echo bytes, values, flags and latency.
//   Honours DEC_LINE_READER_BACKSPACE_EN for the backspace cases.
module tb_dec_line_reader;

    localparam int MAXD  = 5;
    localparam int VAL_W = 16;
    localparam longint VMAX = (64'd1 << VAL_W) - 1;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [VAL_W-1:0]  value;
    logic              ovf;
    logic [2:0]        ndigits;

    dec_line_reader_if u_if ();

    dec_line_reader #(
        .MAX_DIGITS (MAXD),
        .VAL_W      (VAL_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .uart    (u_if),
        .busy    (busy),
        .done    (done),
        .value   (value),
        .ovf     (ovf),
        .ndigits (ndigits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- line-level model ----------------
    int     ph;          // 0 idle, 1 collecting, 2 converting, 3 done
    int     q[$];        // buffered digits, oldest first
    bit     pend;
    bit     pcr;
    logic [7:0] pbyte;
    int     left;
    longint mval;
    bit     movf;
    longint v;

    // observations for directed checks
    int         cyc = 0;
    logic [7:0] tx_log[$];
    int         tx_cyc_q[$];
    int         cr_cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [31:0] got_val = 0;
    logic [31:0] got_ovf = 0;
    logic [31:0] got_nd = 0;

    task automatic model_clear();
        q.delete();
        pend = 0;
        pcr  = 0;
        mval = 0;
        movf = 0;
    endtask

    initial begin
        bit e_tx;
        ph = 0;
        model_clear();
        pbyte = 0;
        left = 0;
        forever begin
            @(posedge clk);
            #8;
            cyc++;
            if (!reset_n) begin
                ph = 0;
                model_clear();
            end
            e_tx = pend && !u_if.is_transmitting && !start && reset_n;

            chk("busy",     busy,           ph != 0);
            chk("done",     done,           ph == 3);
            chk("transmit", u_if.transmit,  e_tx);
            chk("ndigits",  ndigits,        q.size());
            chk("value",    value,          mval[31:0]);
            chk("ovf",      ovf,            movf);
            if (e_tx)     chk("tx_byte", u_if.tx_byte, pbyte);
            if (!reset_n) chk("tx_byte_rst", u_if.tx_byte, 0);

            if (u_if.transmit) begin
                tx_log.push_back(u_if.tx_byte);
                tx_cyc_q.push_back(cyc);
                if (u_if.tx_byte == 8'h0D) cr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                got_val  = value;
                got_ovf  = ovf;
                got_nd   = ndigits;
            end

            if (reset_n) begin
                if (start) begin
                    ph = 1;
                    model_clear();
                end else begin
                    case (ph)
                        1: begin
                            if (e_tx) begin
                                pend = 0;
                                if (pcr) begin
                                    pcr  = 0;
                                    ph   = 2;
                                    left = (q.size() == 0) ? 1 : q.size();
                                end
                            end else if (u_if.received && !pend) begin
                                if (u_if.rx_byte >= 8'h30 && u_if.rx_byte <= 8'h39 && q.size() < MAXD) begin
                                    q.push_back(int'(u_if.rx_byte) - 'h30);
                                    pend  = 1;
                                    pbyte = u_if.rx_byte;
                                end else if (u_if.rx_byte == 8'h0D) begin
                                    pend  = 1;
                                    pcr   = 1;
                                    pbyte = 8'h0D;
                                end
`ifdef DEC_LINE_READER_BACKSPACE_EN
                                else if ((u_if.rx_byte == 8'h08 || u_if.rx_byte == 8'h7F) && q.size() > 0) begin
                                    void'(q.pop_back());
                                    pend  = 1;
                                    pbyte = 8'h08;
                                end
`endif
                            end
                        end
                        2: begin
                            left--;
                            if (left == 0) begin
                                v = 0;
                                for (int i = 0; i < q.size(); i++) v = v * 10 + q[i];
                                if (v > VMAX) begin
                                    mval = VMAX;
                                    movf = 1;
                                end else begin
                                    mval = v;
                                    movf = 0;
                                end
                                ph = 3;
                            end
                        end
                        3: ph = 0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.received = 1'b1;
        u_if.rx_byte  = b;
        tick();
        u_if.received = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    endtask

    task automatic line_case(input string nm, input string s, input string etx,
                             input int ev, input int eovf, input int e_nd);
        int d0;
        do_start();
        tx_log.delete();
        tx_cyc_q.delete();
        d0 = done_cnt;
        send_str(s);
        send_byte(8'h0D);
        wait_done(d0, 40);
        repeat (3) tick();
        chk({nm, "_ndone"}, done_cnt - d0, 1);
        chk({nm, "_val"},   got_val, ev);
        chk({nm, "_ovf"},   got_ovf, eovf);
        chk({nm, "_nd"},    got_nd,  e_nd);
        chk({nm, "_ntx"},   tx_log.size(), etx.len() + 1);
        for (int i = 0; i < etx.len() && i < tx_log.size(); i++)
            chk($sformatf("%s_tx%0d", nm, i), tx_log[i], etx[i]);
        if (tx_log.size() > 0) chk({nm, "_txcr"}, tx_log[tx_log.size()-1], 8'h0D);
        chk({nm, "_lat"}, done_cyc - cr_cyc, ((e_nd == 0) ? 1 : e_nd) + 1);
    endtask

    initial begin
        int fall_cyc;
        int d0;
        reset_n = 1'b0;
        start = 1'b0;
        u_if.received = 1'b0;
        u_if.rx_byte = 8'h00;
        u_if.is_transmitting = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_val",  value, 0);
        chk("rst_nd",   ndigits, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        line_case("l123",  "123",    "123",   123,   0, 3);
        line_case("l65535","65535",  "65535", 65535, 0, 5);
        line_case("l99999","99999",  "99999", 65535, 1, 5);
        line_case("l6dig", "123456", "12345", 12345, 0, 5);
        line_case("l4a5",  "4a5",    "45",    45,    0, 2);
        line_case("lcr",   "",       "",      0,     0, 0);
`ifdef DEC_LINE_READER_BACKSPACE_EN
        line_case("lbs",  $sformatf("12%c3", 8'h08), $sformatf("12%c3", 8'h08), 13, 0, 2);
        line_case("ldel", $sformatf("9%c", 8'h7F),   $sformatf("9%c", 8'h08),   0,  0, 0);
`else
        line_case("lbs",  $sformatf("12%c3", 8'h08), "123", 123, 0, 3);
        line_case("ldel", $sformatf("9%c", 8'h7F),   "9",   9,   0, 1);
`endif

        // echo held off by a busy transmitter; second byte dropped
        do_start();
        tx_log.delete();
        tx_cyc_q.delete();
        u_if.is_transmitting = 1'b1;
        u_if.received = 1'b1;
        u_if.rx_byte  = 8'h37;
        tick();
        u_if.received = 1'b0;
        repeat (9) tick();
        u_if.received = 1'b1;
        u_if.rx_byte  = 8'h38;
        tick();
        u_if.received = 1'b0;
        repeat (3) tick();
        chk("busytx_none", tx_log.size(), 0);
        u_if.is_transmitting = 1'b0;
        fall_cyc = cyc + 1;
        repeat (3) tick();
        chk("busytx_n",    tx_log.size(), 1);
        if (tx_log.size() > 0) begin
            chk("busytx_byte", tx_log[0], 8'h37);
            chk("busytx_cyc",  tx_cyc_q[0], fall_cyc);
        end
        chk("busytx_nd", ndigits, 1);
        d0 = done_cnt;
        send_byte(8'h0D);
        wait_done(d0, 20);
        tick();
        chk("busytx_ndone", done_cnt - d0, 1);
        chk("busytx_val",   got_val, 7);

        // reset during CONVERT
        do_start();
        d0 = done_cnt;
        send_str("99");
        send_byte(8'h0D);
        chk("rstcv_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("rstcv_busy", busy, 0);
        chk("rstcv_done", done, 0);
        chk("rstcv_tx",   u_if.transmit, 0);
        chk("rstcv_txb",  u_if.tx_byte, 0);
        chk("rstcv_val",  value, 0);
        chk("rstcv_ovf",  ovf, 0);
        chk("rstcv_nd",   ndigits, 0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("rstcv_busy_after", busy, 0);
        chk("rstcv_nodone", done_cnt - d0, 0);

        line_case("lpost", "5", "5", 5, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_line_reader.md
DEC_LINE_READER -- requirements
Module: dec_line_reader

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 5: maximum digits accepted per line.
REQ-002 SHALL have parameter VAL_W, default 16: width of the converted value.
REQ-003 SHALL have port clk  input  1  system clock (100 MHz).
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; clear buffer, begin a new line.
REQ-006 SHALL have port received  input  1  one-cycle UART receive strobe.
REQ-007 SHALL have port rx_byte  input  8  received byte, valid only with received.
REQ-008 SHALL have port is_transmitting  input  1  UART transmitter busy.
REQ-009 SHALL have port transmit  output  1  one-cycle echo request to the UART.
REQ-010 SHALL have port tx_byte  output  8  echo byte, stable in the transmit cycle.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when value is valid.
REQ-013 SHALL have port value  output  VAL_W  converted number, held until the next start.
REQ-014 SHALL have port ovf  output  1  conversion saturated; held with value.
REQ-015 SHALL have port ndigits  output  $clog2(MAX_DIGITS+1)  digits currently buffered.

Function
REQ-016 SHALL implement the states IDLE, COLLECT, CONVERT and DONE; start in any state SHALL go to COLLECT, clear ndigits and ovf, and discard any pending echo.
REQ-017 In COLLECT, when received is high, rx_byte is in 0x30..0x39, ndigits<MAX_DIGITS and no echo is pending, the block SHALL store the digit, increment ndigits and queue an echo of rx_byte.
REQ-018 Other non-digits, digits received when the buffer is full, and any byte received while an echo is pending SHALL be ignored and not echoed.
REQ-019 In COLLECT, 0x0D SHALL be accepted even with 0 digits; it SHALL queue an echo of 0x0D and enter CONVERT only after that echo's transmit pulse.
REQ-020 The echo rule SHALL apply to every queued echo: transmit pulses exactly once, no earlier than the cycle after acceptance, and in the first cycle with is_transmitting==0.
REQ-021 tx_byte SHALL be held from acceptance through the transmit cycle.
REQ-022 In CONVERT, the block SHALL apply acc=acc*10+digit, one digit per cycle, oldest digit first, with an internal width of at least VAL_W+4; latency SHALL be max(ndigits,1) cycles.
REQ-023 If acc exceeds 2^VAL_W-1, value SHALL saturate to all-ones and ovf SHALL be set.
REQ-024 CONVERT SHALL be followed by DONE for exactly one cycle, with done=1 and value/ovf updated; the block SHALL then return to IDLE.
REQ-025 received SHALL be ignored in IDLE, CONVERT and DONE.

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE and set transmit, tx_byte, busy, done, value, ovf, ndigits and all internal buffers to 0, including during CONVERT or with an echo pending.

Configuration
REQ-027 With DEC_LINE_READER_BACKSPACE_EN defined, 0x08 or 0x7F in COLLECT with ndigits>0 SHALL remove the last digit, decrement ndigits and queue an echo of 0x08; with ndigits==0 the byte SHALL be ignored.
REQ-028 Without DEC_LINE_READER_BACKSPACE_EN, 0x08 and 0x7F SHALL be treated as ordinary ignored non-digits.

Structure
REQ-029 Package dec_line_reader_pkg SHALL hold the state enum and the ASCII constants CR=0x0D, BS=0x08, DEL=0x7F, DIG0=0x30, DIG9=0x39.
REQ-030 The Horner multiply-add-saturate datapath SHALL be the sub-module dec_accum; the FSM, digit buffer and echo logic SHALL remain in dec_line_reader.

Verification
REQ-031 Bench SHALL cover: start, then "123",CR with is_transmitting=0 -> transmit bytes 0x31,0x32,0x33,0x0D; one done pulse; value=123, ndigits=3, ovf=0.
REQ-032 Bench SHALL cover: "65535",CR -> value=0xFFFF, ovf=0; new start, then "99999",CR -> value=0xFFFF, ovf=1.
REQ-033 Bench SHALL cover: "123456",CR -> sixth digit not echoed; "4a5",CR -> 'a' not echoed; values 12345 and 45.
REQ-034 Bench SHALL cover: is_transmitting=1 when '7' is received, plus '8' received 10 cycles later -> a single transmit with tx_byte=0x37 in the first cycle after is_transmitting falls; '8' is dropped.
REQ-035 Bench SHALL cover: "12",0x08,"3",CR -> value=13 with the macro defined and 123 without it; CR alone -> value=0, done after 1 CONVERT cycle.
REQ-036 Bench SHALL cover: reset_n low mid-CONVERT -> all outputs 0 in the same cycle; busy=0 after release.
